updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter_if.sv | 26 ++
 rtl/updown_mod_counter.sv | 81 ++++++++
 tb/tb_updown_mod_counter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master side drives the controls; the slave side returns the registered status.
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] gray;
    logic             tc;
    logic             ovf;

    modport master (
        output clear, load, load_val, en, up, sat,
        input  count, gray, tc, ovf
    );

    modport slave (
        input  clear, load, load_val, en, up, sat,
        output count, gray, tc, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with wrap/saturate boundary mode, Gray output,
// terminal-count pulse and sticky overflow flag.
module updown_mod_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_mod_counter_if.slave   bus
);
    // MODULUS is kept 64-bit so that 2**32 is representable at WIDTH = 32.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] gray_q,  gray_d;
    logic             tc_q,    tc_d;
    logic             ovf_q,   ovf_d;
    logic             at_max;
    logic             at_zero;
    logic             load_oor;

    assign at_max   = (count_q == MAX_CNT);
    assign at_zero  = (count_q == '0);
    assign load_oor = (64'(bus.load_val) >= MODULUS);

    // Priority: clear > load > en; otherwise hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (bus.clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            if (load_oor) begin
                count_d = MAX_CNT;
                ovf_d   = 1'b1;
            end else begin
                count_d = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = bus.sat ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                    count_d = bus.sat ? count_q : MAX_CNT;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        gray_d = count_d ^ (count_d >> 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            gray_q  <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            gray_q  <= gray_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.gray  = gray_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH = 4, MODULUS = 10):
// a vector table for single-edge behaviour plus hand-written reset and toggle sequences.
module tb_updown_mod_counter;
    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 10;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    updown_mod_counter_if #(.WIDTH(W)) bus ();

    updown_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         clr;
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic         up;
        logic         sat;
        logic [W-1:0] cnt;
        logic [W-1:0] gry;
        logic         tc;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic ld, input logic [W-1:0] lv,
                       input logic en, input logic up, input logic sat,
                       input logic [W-1:0] cnt, input logic [W-1:0] gry,
                       input logic tc, input logic ovf);
        vec_t v;
        v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.up = up; v.sat = sat;
        v.cnt = cnt; v.gry = gry; v.tc = tc; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] c, input logic [W-1:0] g,
                             input logic t, input logic o);
        check({tag, ".count"}, 32'(bus.count), 32'(c));
        check({tag, ".gray"},  32'(bus.gray),  32'(g));
        check({tag, ".tc"},    32'(bus.tc),    32'(t));
        check({tag, ".ovf"},   32'(bus.ovf),   32'(o));
    endtask

    task automatic drive(input logic clr, input logic ld, input logic [W-1:0] lv,
                         input logic en, input logic up, input logic sat);
        bus.clear = clr; bus.load = ld; bus.load_val = lv;
        bus.en = en; bus.up = up; bus.sat = sat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        drive(0, 0, 4'd0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_all("reset_init", 4'd0, 4'd0, 0, 0);

        // Inputs must be ignored while reset is held across an edge.
        drive(0, 1, 4'd6, 1, 1, 0);
        step();
        check_all("reset_held", 4'd0, 4'd0, 0, 0);
        drive(0, 0, 4'd0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Count up with wrap for 12 edges.
        add(0,0,0, 1,1,0, 4'd1, 4'b0001, 0,0);
        add(0,0,0, 1,1,0, 4'd2, 4'b0011, 0,0);
        add(0,0,0, 1,1,0, 4'd3, 4'b0010, 0,0);
        add(0,0,0, 1,1,0, 4'd4, 4'b0110, 0,0);
        add(0,0,0, 1,1,0, 4'd5, 4'b0111, 0,0);
        add(0,0,0, 1,1,0, 4'd6, 4'b0101, 0,0);
        add(0,0,0, 1,1,0, 4'd7, 4'b0100, 0,0);
        add(0,0,0, 1,1,0, 4'd8, 4'b1100, 0,0);
        add(0,0,0, 1,1,0, 4'd9, 4'b1101, 0,0);
        add(0,0,0, 1,1,0, 4'd0, 4'b0000, 1,1);
        add(0,0,0, 1,1,0, 4'd1, 4'b0001, 0,1);
        add(0,0,0, 1,1,0, 4'd2, 4'b0011, 0,1);
        add(1,0,0, 0,0,0, 4'd0, 4'b0000, 0,0);
        // Load 3 then saturating count down.
        add(0,1,4'd3, 0,0,0, 4'd3, 4'b0010, 0,0);
        add(0,0,0, 1,0,1, 4'd2, 4'b0011, 0,0);
        add(0,0,0, 1,0,1, 4'd1, 4'b0001, 0,0);
        add(0,0,0, 1,0,1, 4'd0, 4'b0000, 0,0);
        add(0,0,0, 1,0,1, 4'd0, 4'b0000, 1,1);
        add(0,0,0, 1,0,1, 4'd0, 4'b0000, 1,1);
        add(0,0,0, 0,0,1, 4'd0, 4'b0000, 0,1);
        // Out-of-range load and clear.
        add(1,0,0, 0,0,0, 4'd0, 4'b0000, 0,0);
        add(0,1,4'd12, 0,0,0, 4'd9, 4'b1101, 0,1);
        add(1,0,0, 0,0,0, 4'd0, 4'b0000, 0,0);
        add(0,1,4'd10, 0,0,0, 4'd9, 4'b1101, 0,1);
        add(0,1,4'd15, 1,1,0, 4'd9, 4'b1101, 0,1);
        add(1,0,0, 0,0,0, 4'd0, 4'b0000, 0,0);
        // Priority: clear > load > en.
        add(0,1,4'd5, 0,0,0, 4'd5, 4'b0111, 0,0);
        add(1,1,4'd7, 1,1,0, 4'd0, 4'b0000, 0,0);
        add(0,1,4'd7, 1,1,0, 4'd7, 4'b0100, 0,0);
        add(0,1,4'd9, 1,0,0, 4'd9, 4'b1101, 0,0);
        // Saturate up at the top, then hold.
        add(0,1,4'd8, 0,0,0, 4'd8, 4'b1100, 0,0);
        add(0,0,0, 1,1,1, 4'd9, 4'b1101, 0,0);
        add(0,0,0, 1,1,1, 4'd9, 4'b1101, 1,1);
        add(0,0,0, 1,1,1, 4'd9, 4'b1101, 1,1);
        add(0,0,0, 0,1,1, 4'd9, 4'b1101, 0,1);
        // Direction/mode change takes effect immediately: wrap down from 0.
        add(1,0,0, 0,0,0, 4'd0, 4'b0000, 0,0);
        add(0,0,0, 1,0,0, 4'd9, 4'b1101, 1,1);
        add(0,0,0, 1,0,0, 4'd8, 4'b1100, 0,1);
        add(0,0,0, 1,1,0, 4'd9, 4'b1101, 0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].sat);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].gry, vecs[i].tc, vecs[i].ovf);
        end

        // Asynchronous reset between edges at count = 7.
        drive(0, 1, 4'd7, 0, 0, 0);
        step();
        check_all("pre_async", 4'd7, 4'b0100, 0, 1);
        drive(0, 0, 4'd0, 1, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 4'd0, 4'd0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_all("resume", 4'd1, 4'b0001, 0, 0);

        // Reset during a tc pulse leaves no residual pulse.
        drive(0, 1, 4'd9, 0, 0, 0);
        step();
        drive(0, 0, 4'd0, 1, 1, 0);
        step();
        check_all("tc_pulse", 4'd0, 4'd0, 1, 1);
        drive(0, 0, 4'd0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_all("tc_abort", 4'd0, 4'd0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_all("tc_after", 4'd0, 4'd0, 0, 0);

        // Toggle direction every edge from 0 with wrap: 9,0,9,0... tc every cycle.
        drive(1, 0, 4'd0, 0, 0, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 4'd0, 1, logic'(i % 2), 0);
            step();
            check($sformatf("tog%0d.count", i), 32'(bus.count), (i % 2 == 0) ? 32'd9 : 32'd0);
            check($sformatf("tog%0d.tc", i), 32'(bus.tc), 32'd1);
            check($sformatf("tog%0d.range", i), 32'(bus.count < 4'(MOD)), 32'd1);
        end
        check("tog.ovf", 32'(bus.ovf), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
